adder_result_fifo: RTL

//  Downstream capture stage for the 4-bit ripple-carry adder. Accepts each
//  {COUT,SUM} result under a valid/ready handshake and buffers it in a small

---
 rtl/adder_result_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/adder_result_fifo.sv
// Capture FIFO for {COUT,SUM} adder results, plus a saturating carry-out counter.
// Latency: a result pushed into an empty FIFO is on OUT_DATA one edge later; no bypass.
// Backpressure: IN_READY drops while all DEPTH entries are held; a pop frees the slot from the next cycle.
module adder_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [0:3]             SUM,
    input  logic                   COUT,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [0:4]             OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [0:$clog2(DEPTH)] LEVEL,
    output logic [0:CNT_W-1]       CARRY_CNT,
    input  logic                   CLR_CNT
);

    // Pointer width and occupancy width (occupancy needs one more bit to hold DEPTH).
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]    LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0]    LVL_EMPTY = '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // One captured adder result; cout lands on OUT_DATA[0], sum MSB on OUT_DATA[1].
    typedef struct packed {
        logic       cout;
        logic [3:0] sum;
    } result_t;

    result_t          in_dat;
    result_t          out_dat;
    result_t          mem [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] carry_cnt;

    logic             in_rdy;
    logic             out_vld;
    logic             push;
    logic             pop;

    assign in_dat = '{cout: COUT, sum: SUM};

    // Handshake flags come straight from the registered occupancy, so there is
    // no combinational path from the input side to the output side.
    assign in_rdy  = (level != LVL_FULL);
    assign out_vld = (level != LVL_EMPTY);

    assign push = IN_VALID  & in_rdy;
    assign pop  = out_vld   & OUT_READY;

    // Storage write; entries are cleared on reset so OUT_DATA reads zero afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Write/read pointers; DEPTH is a power of two so they wrap by natural overflow.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy counter; push and pop on the same edge cancel out.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Saturating count of accepted results with a carry-out; clear beats increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            carry_cnt <= '0;
        end else if (CLR_CNT) begin
            carry_cnt <= '0;
        end else if (push && COUT && (carry_cnt != CNT_MAX)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

    // Head of the queue is always the entry under the read pointer.
    assign out_dat = mem[rd_ptr];

    assign IN_READY  = in_rdy;
    assign OUT_VALID = out_vld;
    assign OUT_DATA  = out_dat;
    assign LEVEL     = level;
    assign CARRY_CNT = carry_cnt;

endmodule
